// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection control slice: walk arbiter state
// encodings and the default crosswalk count.
package traffic_pkg;

    localparam int NUM_REQ_DFLT = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQUEST = 3'd1;
    localparam logic [2:0] ST_SERVE   = 3'd2;
    localparam logic [2:0] ST_PREEMPT = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;

endpackage

// File: rtl/walk_arbiter_rr_pick.sv
// Combinational round-robin selector: the first set bit at or after
// (rr_ptr+1) mod NUM_REQ wins, searching upward with wrap.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               any_valid
);

    logic [PTR_W-1:0] idx;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (pending[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/walk_arbiter.sv
// Shares one pedestrian walk phase among several crosswalk buttons, with
// emergency preemption overriding everything.
//
// state   | meaning
// IDLE    | nothing granted; pick a pending crosswalk or enter preempt
// REQUEST | slot_req high for grant_id, waiting on slot_ack
// SERVE   | walk phase running for grant_id, waiting on slot_done
// PREEMPT | emergency override; handshake outputs held low
// GAP     | one idle cycle so slot_req always drops between slots
module walk_arbiter
    import traffic_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DFLT,
    parameter int PTR_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] walk_req,
    input  logic               preempt,
    input  logic               slot_ack,
    input  logic               slot_done,
    output logic               slot_req,
    output logic               grant_valid,
    output logic [PTR_W-1:0]   grant_id,
    output logic [NUM_REQ-1:0] pending,
    output logic               preempt_active,
    output logic [NUM_REQ-1:0] serviced
);

    logic [2:0]         state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt, grant_id_nxt, winner;
    logic [NUM_REQ-1:0] pending_nxt, serviced_nxt, grant_oh, req_in;
    logic               any_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .pending   (pending),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        grant_id_nxt = grant_id;
        serviced_nxt = '0;
        // The crosswalk being walked cannot re-arm itself.
        req_in       = (state == ST_SERVE) ? (walk_req & ~grant_oh) : walk_req;
        pending_nxt  = pending | req_in;
        case (state)
            ST_IDLE: begin
                if (preempt) begin
                    state_nxt = ST_PREEMPT;
                end else if (any_valid) begin
                    grant_id_nxt = winner;
                    state_nxt    = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (preempt)       state_nxt = ST_PREEMPT;
                else if (slot_ack) state_nxt = ST_SERVE;
            end
            ST_SERVE: begin
                if (preempt) begin
                    state_nxt = ST_PREEMPT;
                end else if (slot_done) begin
                    pending_nxt  = pending_nxt & ~grant_oh;
                    serviced_nxt = grant_oh;
                    rr_ptr_nxt   = grant_id;
                    state_nxt    = ST_GAP;
                end
            end
            ST_PREEMPT: begin
                if (!preempt) state_nxt = ST_GAP;
            end
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pending  <= '0;
            rr_ptr   <= PTR_W'(NUM_REQ - 1);
            grant_id <= '0;
            serviced <= '0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant_id <= grant_id_nxt;
            serviced <= serviced_nxt;
        end
    end

    assign slot_req       = (state == ST_REQUEST);
    assign grant_valid    = (state == ST_SERVE);
    assign preempt_active = (state == ST_PREEMPT);

endmodule

// File: tb/tb_walk_arbiter.sv
// Directed bench for walk_arbiter: reset, single and multi-crosswalk service,
// request absorption, preemption, ignored handshakes, asynchronous reset.
module tb_walk_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] walk_req;
    logic       preempt, slot_ack, slot_done;
    logic       slot_req, grant_valid, preempt_active;
    logic [1:0] grant_id;
    logic [3:0] pending, serviced;

    int passed = 0;
    int total  = 0;

    walk_arbiter #(.NUM_REQ(4), .PTR_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .walk_req       (walk_req),
        .preempt        (preempt),
        .slot_ack       (slot_ack),
        .slot_done      (slot_done),
        .slot_req       (slot_req),
        .grant_valid    (grant_valid),
        .grant_id       (grant_id),
        .pending        (pending),
        .preempt_active (preempt_active),
        .serviced       (serviced)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        walk_req  = 4'b0000;
        preempt   = 1'b0;
        slot_ack  = 1'b0;
        slot_done = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (slot_req !== 1'b0) $display("FAIL reset_slot_req got %b exp 0", slot_req); else passed++;
        total++; if (grant_valid !== 1'b0) $display("FAIL reset_grant_valid got %b exp 0", grant_valid); else passed++;
        total++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id got %0d exp 0", grant_id); else passed++;
        total++; if (pending !== 4'b0000) $display("FAIL reset_pending got %b exp 0000", pending); else passed++;
        total++; if (preempt_active !== 1'b0) $display("FAIL reset_preempt_active got %b exp 0", preempt_active); else passed++;
        total++; if (serviced !== 4'b0000) $display("FAIL reset_serviced got %b exp 0000", serviced); else passed++;
    endtask

    task automatic test_single();
        walk_req = 4'b0100;
        step();
        walk_req = 4'b0000;
        total++; if (pending !== 4'b0100) $display("FAIL single_latch got %b exp 0100", pending); else passed++;
        total++; if (slot_req !== 1'b0) $display("FAIL single_req_early got %b exp 0", slot_req); else passed++;
        step();
        total++; if (slot_req !== 1'b1) $display("FAIL single_req got %b exp 1", slot_req); else passed++;
        total++; if (grant_id !== 2'd2) $display("FAIL single_id got %0d exp 2", grant_id); else passed++;
        slot_ack = 1'b1;
        step();
        slot_ack = 1'b0;
        total++; if (grant_valid !== 1'b1) $display("FAIL single_gv got %b exp 1", grant_valid); else passed++;
        total++; if (slot_req !== 1'b0) $display("FAIL single_req_drop got %b exp 0", slot_req); else passed++;
        step();
        total++; if (grant_valid !== 1'b1) $display("FAIL single_gv_hold got %b exp 1", grant_valid); else passed++;
        slot_done = 1'b1;
        step();
        slot_done = 1'b0;
        total++; if (serviced !== 4'b0100) $display("FAIL single_serviced got %b exp 0100", serviced); else passed++;
        total++; if (pending !== 4'b0000) $display("FAIL single_pending got %b exp 0000", pending); else passed++;
        total++; if (grant_valid !== 1'b0) $display("FAIL single_gap_gv got %b exp 0", grant_valid); else passed++;
        step();
        total++; if (serviced !== 4'b0000) $display("FAIL single_serviced_pulse got %b exp 0000", serviced); else passed++;
        total++; if ({slot_req, grant_valid, preempt_active} !== 3'b000) $display("FAIL single_idle got %b exp 000", {slot_req, grant_valid, preempt_active}); else passed++;
    endtask

    task automatic test_multi();
        logic [1:0] order [3];
        order = '{2'd0, 2'd1, 2'd3};
        do_reset();
        walk_req = 4'b1011;
        step();
        walk_req = 4'b0000;
        step();
        for (int k = 0; k < 3; k++) begin
            total++; if (slot_req !== 1'b1) $display("FAIL multi_req%0d got %b exp 1", k, slot_req); else passed++;
            total++; if (grant_id !== order[k]) $display("FAIL multi_id%0d got %0d exp %0d", k, grant_id, order[k]); else passed++;
            slot_ack = 1'b1;
            step();
            slot_ack  = 1'b0;
            slot_done = 1'b1;
            step();
            slot_done = 1'b0;
            total++; if (serviced !== (4'b0001 << order[k])) $display("FAIL multi_serviced%0d got %b exp %b", k, serviced, 4'b0001 << order[k]); else passed++;
            total++; if (slot_req !== 1'b0) $display("FAIL multi_gap%0d got %b exp 0", k, slot_req); else passed++;
            step();
            total++; if (slot_req !== 1'b0) $display("FAIL multi_idle%0d got %b exp 0", k, slot_req); else passed++;
            step();
        end
        total++; if (pending !== 4'b0000) $display("FAIL multi_pending got %b exp 0000", pending); else passed++;
        total++; if (slot_req !== 1'b0) $display("FAIL multi_final_req got %b exp 0", slot_req); else passed++;
    endtask

    task automatic test_absorb();
        do_reset();
        walk_req = 4'b0010;
        step();
        walk_req = 4'b0000;
        step();
        slot_ack = 1'b1;
        step();
        slot_ack = 1'b0;
        walk_req = 4'b0110;
        step();
        total++; if (pending !== 4'b0110) $display("FAIL absorb_mid got %b exp 0110", pending); else passed++;
        walk_req  = 4'b0010;
        slot_done = 1'b1;
        step();
        clear_in();
        total++; if (pending !== 4'b0100) $display("FAIL absorb_done got %b exp 0100", pending); else passed++;
        total++; if (serviced !== 4'b0010) $display("FAIL absorb_serviced got %b exp 0010", serviced); else passed++;
        step();
        step();
        total++; if (slot_req !== 1'b1) $display("FAIL absorb_next_req got %b exp 1", slot_req); else passed++;
        total++; if (grant_id !== 2'd2) $display("FAIL absorb_next_id got %0d exp 2", grant_id); else passed++;
    endtask

    task automatic test_preempt_serve();
        do_reset();
        walk_req = 4'b0001;
        step();
        walk_req = 4'b0000;
        step();
        slot_ack = 1'b1;
        step();
        slot_ack = 1'b0;
        preempt  = 1'b1;
        step();
        total++; if (preempt_active !== 1'b1) $display("FAIL pre_active got %b exp 1", preempt_active); else passed++;
        total++; if (grant_valid !== 1'b0) $display("FAIL pre_gv got %b exp 0", grant_valid); else passed++;
        total++; if (pending !== 4'b0001) $display("FAIL pre_pending got %b exp 0001", pending); else passed++;
        walk_req = 4'b1000;
        step();
        walk_req = 4'b0000;
        total++; if (pending !== 4'b1001) $display("FAIL pre_latch got %b exp 1001", pending); else passed++;
        total++; if (slot_req !== 1'b0) $display("FAIL pre_req got %b exp 0", slot_req); else passed++;
        preempt = 1'b0;
        step();
        total++; if ({slot_req, grant_valid, preempt_active} !== 3'b000) $display("FAIL pre_gap got %b exp 000", {slot_req, grant_valid, preempt_active}); else passed++;
        step();
        total++; if (slot_req !== 1'b0) $display("FAIL pre_idle got %b exp 0", slot_req); else passed++;
        step();
        total++; if (slot_req !== 1'b1) $display("FAIL pre_rereq got %b exp 1", slot_req); else passed++;
        total++; if (grant_id !== 2'd0) $display("FAIL pre_reid got %0d exp 0", grant_id); else passed++;
        // Now in REQUEST for id 0: preempt beats a simultaneous ack.
        preempt  = 1'b1;
        slot_ack = 1'b1;
        step();
        slot_ack = 1'b0;
        total++; if (preempt_active !== 1'b1) $display("FAIL race_active got %b exp 1", preempt_active); else passed++;
        total++; if (grant_valid !== 1'b0) $display("FAIL race_gv got %b exp 0", grant_valid); else passed++;
        total++; if (slot_req !== 1'b0) $display("FAIL race_req got %b exp 0", slot_req); else passed++;
        preempt = 1'b0;
        step();
        step();
        step();
        total++; if (slot_req !== 1'b1) $display("FAIL race_rereq got %b exp 1", slot_req); else passed++;
        total++; if (grant_id !== 2'd0) $display("FAIL race_reid got %0d exp 0", grant_id); else passed++;
        // ack together with done in REQUEST: only ack is taken.
        slot_ack  = 1'b1;
        slot_done = 1'b1;
        step();
        clear_in();
        total++; if (grant_valid !== 1'b1) $display("FAIL ackdone_gv got %b exp 1", grant_valid); else passed++;
        total++; if (serviced !== 4'b0000) $display("FAIL ackdone_serviced got %b exp 0000", serviced); else passed++;
    endtask

    task automatic test_stray();
        do_reset();
        slot_done = 1'b1;
        slot_ack  = 1'b1;
        step();
        clear_in();
        total++; if ({slot_req, grant_valid, preempt_active} !== 3'b000) $display("FAIL stray_state got %b exp 000", {slot_req, grant_valid, preempt_active}); else passed++;
        total++; if (serviced !== 4'b0000) $display("FAIL stray_serviced got %b exp 0000", serviced); else passed++;
        step();
        total++; if (slot_req !== 1'b0) $display("FAIL stray_idle got %b exp 0", slot_req); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        walk_req = 4'b0001;
        step();
        walk_req = 4'b0000;
        step();
        slot_ack = 1'b1;
        step();
        slot_ack  = 1'b0;
        slot_done = 1'b1;
        step();
        slot_done = 1'b0;
        step();
        walk_req = 4'b0100;
        step();
        walk_req = 4'b0000;
        step();
        total++; if (slot_req !== 1'b1) $display("FAIL mid_pre_req got %b exp 1", slot_req); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (slot_req !== 1'b0) $display("FAIL mid_req_drop got %b exp 0", slot_req); else passed++;
        total++; if (pending !== 4'b0000) $display("FAIL mid_pending got %b exp 0000", pending); else passed++;
        total++; if (grant_valid !== 1'b0) $display("FAIL mid_gv got %b exp 0", grant_valid); else passed++;
        #2;
        rst_n    = 1'b1;
        walk_req = 4'b1001;
        step();
        walk_req = 4'b0000;
        step();
        total++; if (slot_req !== 1'b1) $display("FAIL mid_after_req got %b exp 1", slot_req); else passed++;
        total++; if (grant_id !== 2'd0) $display("FAIL mid_after_id got %0d exp 0", grant_id); else passed++;
    endtask

    initial begin
        clear_in();
        rst_n = 1'b0;
        #3;
        test_reset();
        test_single();
        test_multi();
        test_absorb();
        test_preempt_serve();
        test_stray();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
